// File: rtl/fifo_read_sequencer_pkg.sv
// fifo_seq_pkg: shared definitions for the FIFO read sequencer.
//   STATE_W       width of the FSM state / fsm_state_o
//   fsm_state_t   state encoding (IDLE=0 .. WAIT_HYBD=4)
package fifo_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        WAIT_TX   = 3'd1,
        READ      = 3'd2,
        WAIT_LOOP = 3'd3,
        WAIT_HYBD = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/fifo_read_sequencer_if.sv
// fifo_read_sequencer_if: handshake and FIFO read bus of the sequencer.
//   Inputs to the sequencer : sync_done, tx_w_done, loop_done, hybd_done,
//                             bypass_hybd, fifo_empty[NUM_CH]
//   Outputs of the sequencer: r_en, rd_strobe, ch_sel, burst_cnt, stall,
//                             fsm_state_o
//   master = sequencer side, slave = environment side.
interface fifo_read_sequencer_if #(
    parameter int NUM_CH      = 4,
    parameter int LOG2_NUM_CH = 2,
    parameter int CNT_W       = 8
);
    import fifo_seq_pkg::*;

    logic                   sync_done;
    logic                   tx_w_done;
    logic                   loop_done;
    logic                   hybd_done;
    logic                   bypass_hybd;
    logic [NUM_CH-1:0]      fifo_empty;
    logic                   r_en;
    logic                   rd_strobe;
    logic [LOG2_NUM_CH-1:0] ch_sel;
    logic [CNT_W-1:0]       burst_cnt;
    logic                   stall;
    logic [STATE_W-1:0]     fsm_state_o;

    modport master (
        input  sync_done, tx_w_done, loop_done, hybd_done, bypass_hybd, fifo_empty,
        output r_en, rd_strobe, ch_sel, burst_cnt, stall, fsm_state_o
    );

    modport slave (
        output sync_done, tx_w_done, loop_done, hybd_done, bypass_hybd, fifo_empty,
        input  r_en, rd_strobe, ch_sel, burst_cnt, stall, fsm_state_o
    );
endinterface

// File: rtl/fifo_read_sequencer_rd_pacer.sv
// rd_pacer: strobe pacing and channel round-robin for the READ state.
//   clk, reset   clock, synchronous active-high reset
//   active       high while the sequencer is in READ
//   fifo_empty   per-channel empty flags
//   rd_strobe    read pulse to channel ch_sel
//   stall        strobe slot blocked by an empty FIFO
//   frame_done   final strobe of the last channel (this cycle)
//   ch_sel       current channel
//   burst_cnt    strobes issued on the current channel
module rd_pacer #(
    parameter int NUM_CH      = 4,
    parameter int LOG2_NUM_CH = 2,
    parameter int BURST_LEN   = 100,
    parameter int CNT_W       = 8,
    parameter int RD_DIV      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active,
    input  logic [NUM_CH-1:0]      fifo_empty,
    output logic                   rd_strobe,
    output logic                   stall,
    output logic                   frame_done,
    output logic [LOG2_NUM_CH-1:0] ch_sel,
    output logic [CNT_W-1:0]       burst_cnt
);
    localparam int DIV_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

    logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
    logic [CNT_W-1:0]       burst_cnt_reg, burst_cnt_next;
    logic [LOG2_NUM_CH-1:0] ch_sel_reg, ch_sel_next;
    logic [NUM_CH-1:0]      empty_hit;
    logic                   slot, sel_empty, last_strobe, last_ch;

    // Empty flag of the selected channel, built as an AND-OR mux so that
    // non-power-of-two channel counts never index out of range.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_empty_mux
        assign empty_hit[gi] = (ch_sel_reg == LOG2_NUM_CH'(gi)) && fifo_empty[gi];
    end

    assign sel_empty   = |empty_hit;
    assign slot        = active && (div_cnt_reg == '0);
    assign rd_strobe   = slot && !sel_empty;
    assign stall       = slot && sel_empty;
    assign last_strobe = rd_strobe && (burst_cnt_reg == CNT_W'(BURST_LEN - 1));
    assign last_ch     = (ch_sel_reg == LOG2_NUM_CH'(NUM_CH - 1));
    assign frame_done  = last_strobe && last_ch;
    assign ch_sel      = ch_sel_reg;
    assign burst_cnt   = burst_cnt_reg;

    always_comb begin
        div_cnt_next   = div_cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        ch_sel_next    = ch_sel_reg;
        if (!active) begin
            // Holding everything at zero outside READ makes every entry
            // to READ start from channel 0, count 0, strobe slot.
            div_cnt_next   = '0;
            burst_cnt_next = '0;
            ch_sel_next    = '0;
        end else if (stall) begin
            // Freeze on the slot until the FIFO has data again.
        end else if (last_strobe) begin
            // Restart the cadence so the next channel strobes immediately.
            div_cnt_next   = '0;
            burst_cnt_next = '0;
            ch_sel_next    = last_ch ? '0 : ch_sel_reg + LOG2_NUM_CH'(1);
        end else begin
            if (rd_strobe) begin
                burst_cnt_next = burst_cnt_reg + CNT_W'(1);
            end
            div_cnt_next = (div_cnt_reg == DIV_W'(RD_DIV - 1)) ? '0
                                                               : div_cnt_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg   <= '0;
            burst_cnt_reg <= '0;
            ch_sel_reg    <= '0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            ch_sel_reg    <= ch_sel_next;
        end
    end
endmodule

// File: rtl/fifo_read_sequencer.sv
// fifo_read_sequencer: read-side controller for the ECG sample FIFO bank.
// After sync it reads BURST_LEN samples from each of NUM_CH FIFOs in turn,
// then waits for loop / hybrid / transmit-window handshakes per frame.
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    fifo_read_sequencer_if.master (handshakes in, read bus out)
module fifo_read_sequencer
    import fifo_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int LOG2_NUM_CH = 2,
    parameter int BURST_LEN   = 100,
    parameter int CNT_W       = 8,
    parameter int RD_DIV      = 2
) (
    input  logic clk,
    input  logic reset,
    fifo_read_sequencer_if.master bus
);
    fsm_state_t state_reg, state_next;
    logic       frame_done;

    rd_pacer #(
        .NUM_CH      (NUM_CH),
        .LOG2_NUM_CH (LOG2_NUM_CH),
        .BURST_LEN   (BURST_LEN),
        .CNT_W       (CNT_W),
        .RD_DIV      (RD_DIV)
    ) u_rd_pacer (
        .clk        (clk),
        .reset      (reset),
        .active     (state_reg == READ),
        .fifo_empty (bus.fifo_empty),
        .rd_strobe  (bus.rd_strobe),
        .stall      (bus.stall),
        .frame_done (frame_done),
        .ch_sel     (bus.ch_sel),
        .burst_cnt  (bus.burst_cnt)
    );

    // Each handshake is only looked at in the state that consumes it, so
    // early or stray pulses are dropped rather than remembered.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (bus.sync_done) state_next = READ;
            WAIT_TX:   if (bus.tx_w_done) state_next = READ;
            READ:      if (frame_done)    state_next = WAIT_LOOP;
            WAIT_LOOP: if (bus.loop_done) state_next = bus.bypass_hybd ? WAIT_TX : WAIT_HYBD;
            WAIT_HYBD: if (bus.hybd_done) state_next = WAIT_TX;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.r_en        = (state_reg == READ) || (state_reg == WAIT_LOOP) ||
                             (state_reg == WAIT_HYBD);
    assign bus.fsm_state_o = state_reg;
endmodule

// File: tb/tb_fifo_read_sequencer.sv
module tb_fifo_read_sequencer;
    typedef struct {
        int ch;
        int bc;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    // A: single channel, base timing. B: four channels, round robin.
    fifo_read_sequencer_if #(.NUM_CH(1), .LOG2_NUM_CH(1), .CNT_W(8)) if_a ();
    fifo_read_sequencer_if #(.NUM_CH(4), .LOG2_NUM_CH(2), .CNT_W(8)) if_b ();

    fifo_read_sequencer #(.NUM_CH(1), .LOG2_NUM_CH(1), .BURST_LEN(100), .CNT_W(8), .RD_DIV(2))
        u_a (.clk(clk), .reset(rst_a), .bus(if_a));
    fifo_read_sequencer #(.NUM_CH(4), .LOG2_NUM_CH(2), .BURST_LEN(3), .CNT_W(8), .RD_DIV(1))
        u_b (.clk(clk), .reset(rst_b), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    // Scoreboard monitors: every strobe must match the next planned one.
    always @(negedge clk) begin
        if (if_a.rd_strobe) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                $display("a strobe cyc=%0d ch=%0d bc=%0d", cyc, if_a.ch_sel, if_a.burst_cnt);
                check("a_ch", if_a.ch_sel, e.ch);
                check("a_bc", if_a.burst_cnt, e.bc);
                check("a_cyc", cyc, e.cyc);
            end
        end
        if (if_b.rd_strobe) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                $display("b strobe cyc=%0d ch=%0d bc=%0d", cyc, if_b.ch_sel, if_b.burst_cnt);
                check("b_ch", if_b.ch_sel, e.ch);
                check("b_bc", if_b.burst_cnt, e.bc);
                check("b_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        {if_a.sync_done, if_a.tx_w_done, if_a.loop_done, if_a.hybd_done, if_a.bypass_hybd} = '0;
        {if_b.sync_done, if_b.tx_w_done, if_b.loop_done, if_b.hybd_done, if_b.bypass_hybd} = '0;
        if_a.fifo_empty = '0;
        if_b.fifo_empty = '0;
        tick();
        tick();
        check("rst_state", if_a.fsm_state_o, 0);
        check("rst_r_en", if_a.r_en, 0);
        check("rst_strobe", if_a.rd_strobe, 0);
        check("rst_stall", if_a.stall, 0);
        check("rst_ch", if_a.ch_sel, 0);
        check("rst_bc", if_a.burst_cnt, 0);
        check("rst_b_state", if_b.fsm_state_o, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        check("idle_hold", if_a.fsm_state_o, 0);

        // ---- A1: base timing, 100 strobes two cycles apart ----
        t0 = cyc + 1;
        for (int i = 0; i < 100; i++) sb_a.push_back('{0, i, t0 + 2 * i});
        if_a.sync_done = 1'b1; tick(); if_a.sync_done = 1'b0;
        check("a1_enter_read", if_a.fsm_state_o, 2);
        wait_cyc(t0 + 198);
        check("a1_read_last", if_a.fsm_state_o, 2);
        tick();
        check("a1_wait_loop", if_a.fsm_state_o, 3);
        check("a1_r_en", if_a.r_en, 1);
        check("a1_sb_left", sb_a.size(), 0);

        // ---- handshake chain: early tx ignored, 3 -> 4 -> 1 -> READ ----
        if_a.tx_w_done = 1'b1; tick(); if_a.tx_w_done = 1'b0;
        check("hs_tx_early", if_a.fsm_state_o, 3);
        if_a.loop_done = 1'b1; tick(); if_a.loop_done = 1'b0;
        check("hs_loop", if_a.fsm_state_o, 4);
        check("hs_r_en_hybd", if_a.r_en, 1);
        tick();
        check("hs_hybd_hold", if_a.fsm_state_o, 4);
        if_a.hybd_done = 1'b1; tick(); if_a.hybd_done = 1'b0;
        check("hs_hybd", if_a.fsm_state_o, 1);
        check("hs_r_en_tx", if_a.r_en, 0);

        // ---- A2: restart via tx_w_done, reset at burst_cnt=50 ----
        t0 = cyc + 1;
        for (int i = 0; i < 50; i++) sb_a.push_back('{0, i, t0 + 2 * i});
        if_a.tx_w_done = 1'b1; tick(); if_a.tx_w_done = 1'b0;
        check("a2_read", if_a.fsm_state_o, 2);
        check("a2_ch0", if_a.ch_sel, 0);
        check("a2_bc0", if_a.burst_cnt, 0);
        wait_cyc(t0 + 99);
        check("a2_bc50", if_a.burst_cnt, 50);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        check("a2_rst_state", if_a.fsm_state_o, 0);
        check("a2_rst_r_en", if_a.r_en, 0);
        check("a2_rst_strobe", if_a.rd_strobe, 0);
        check("a2_rst_stall", if_a.stall, 0);
        check("a2_rst_ch", if_a.ch_sel, 0);
        check("a2_rst_bc", if_a.burst_cnt, 0);
        check("a2_sb_left", sb_a.size(), 0);
        if_a.tx_w_done = 1'b1; tick(); if_a.tx_w_done = 1'b0;
        tick();
        check("a2_tx_ignored", if_a.fsm_state_o, 0);

        // ---- A3: sync restarts, then bypassed hybrid stage ----
        t0 = cyc + 1;
        for (int i = 0; i < 100; i++) sb_a.push_back('{0, i, t0 + 2 * i});
        if_a.sync_done = 1'b1; tick(); if_a.sync_done = 1'b0;
        wait_cyc(t0 + 199);
        check("a3_wait_loop", if_a.fsm_state_o, 3);
        check("a3_sb_left", sb_a.size(), 0);
        if_a.bypass_hybd = 1'b1;
        if_a.loop_done = 1'b1; tick(); if_a.loop_done = 1'b0;
        if_a.bypass_hybd = 1'b0;
        check("a3_bypass", if_a.fsm_state_o, 1);
        check("a3_r_en", if_a.r_en, 0);

        // ---- B1: round robin, 12 back-to-back strobes ----
        t0 = cyc + 1;
        for (int i = 0; i < 12; i++) sb_b.push_back('{i / 3, i % 3, t0 + i});
        if_b.sync_done = 1'b1; tick(); if_b.sync_done = 1'b0;
        wait_cyc(t0 + 11);
        check("b1_read_last", if_b.fsm_state_o, 2);
        check("b1_ch_last", if_b.ch_sel, 3);
        tick();
        check("b1_wait_loop", if_b.fsm_state_o, 3);
        check("b1_ch_wrap", if_b.ch_sel, 0);
        check("b1_sb_left", sb_b.size(), 0);
        if_b.bypass_hybd = 1'b1;
        if_b.loop_done = 1'b1; if_b.hybd_done = 1'b1; tick();
        if_b.loop_done = 1'b0; if_b.hybd_done = 1'b0; if_b.bypass_hybd = 1'b0;
        check("b1_bypass", if_b.fsm_state_o, 1);

        // ---- B2: empty stall for 5 cycles after first strobe ----
        t0 = cyc + 1;
        sb_b.push_back('{0, 0, t0});
        for (int i = 1; i < 12; i++) sb_b.push_back('{i / 3, i % 3, t0 + i + 5});
        if_b.tx_w_done = 1'b1; tick(); if_b.tx_w_done = 1'b0;
        tick();
        if_b.fifo_empty[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("b2_stall", if_b.stall, 1);
            check("b2_bc_frozen", if_b.burst_cnt, 1);
            tick();
        end
        if_b.fifo_empty[0] = 1'b0;
        #1;
        check("b2_stall_clear", if_b.stall, 0);
        check("b2_resume_strobe", if_b.rd_strobe, 1);
        wait_cyc(t0 + 17);
        check("b2_wait_loop", if_b.fsm_state_o, 3);
        check("b2_sb_left", sb_b.size(), 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
